// File: rtl/sobel_pkg.sv
// Shared types and sizes for the Sobel edge stage.
package sobel_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } state_e;

    localparam int unsigned PIX_W     = 8;
    localparam int unsigned GRAD_W    = 11;
    localparam int unsigned MAG_W     = 10;
    localparam int unsigned IMG_W_DEF = 64;
    localparam int unsigned IMG_H_DEF = 64;

    function automatic logic signed [GRAD_W-1:0] ext(input logic [PIX_W-1:0] p);
        return signed'(GRAD_W'(p));
    endfunction

    function automatic logic [MAG_W-1:0] abs_mag(input logic signed [GRAD_W-1:0] g);
        return MAG_W'(g[GRAD_W-1] ? -g : g);
    endfunction

endpackage

// File: rtl/sobel_stage_if.sv
// Window-in / pixel-out bus between the frame controller and the kernel.
interface sobel_stage_if;
    import sobel_pkg::*;

    logic             in_valid;
    logic [PIX_W-1:0] win [9];
    logic             out_valid;
    logic [PIX_W-1:0] pix_out;

    modport master (output in_valid, win, input out_valid, pix_out);
    modport slave  (input in_valid, win, output out_valid, pix_out);
endinterface

// File: rtl/sobel_kernel.sv
// Three-stage Sobel datapath: gradients, magnitudes, saturated sum.
// Optional binarize output when SOBEL_THRESH_EN is defined.
module sobel_kernel
    import sobel_pkg::*;
#(
    parameter int unsigned THRESH = 128
) (
    input  logic          clk,
    input  logic          rst_n,
    sobel_stage_if.slave  bus
);

    logic signed [GRAD_W-1:0] gx_d, gy_d, gx_q, gy_q;
    logic [MAG_W-1:0]         ax_q, ay_q;
    logic [GRAD_W-1:0]        sum_d;
    logic [PIX_W-1:0]         pix_d, pix_q;
    logic                     v1_q, v2_q, v3_q;

    always_comb begin
        gx_d = (ext(bus.win[2]) + (ext(bus.win[5]) <<< 1) + ext(bus.win[8]))
             - (ext(bus.win[0]) + (ext(bus.win[3]) <<< 1) + ext(bus.win[6]));
        gy_d = (ext(bus.win[6]) + (ext(bus.win[7]) <<< 1) + ext(bus.win[8]))
             - (ext(bus.win[0]) + (ext(bus.win[1]) <<< 1) + ext(bus.win[2]));
    end

    always_comb begin
        sum_d = {1'b0, ax_q} + {1'b0, ay_q};
`ifdef SOBEL_THRESH_EN
        pix_d = (sum_d >= GRAD_W'(THRESH)) ? '1 : '0;
`else
        pix_d = (sum_d > GRAD_W'(255)) ? '1 : sum_d[PIX_W-1:0];
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            v3_q  <= 1'b0;
            gx_q  <= '0;
            gy_q  <= '0;
            ax_q  <= '0;
            ay_q  <= '0;
            pix_q <= '0;
        end else begin
            v1_q  <= bus.in_valid;
            gx_q  <= gx_d;
            gy_q  <= gy_d;
            v2_q  <= v1_q;
            ax_q  <= abs_mag(gx_q);
            ay_q  <= abs_mag(gy_q);
            v3_q  <= v2_q;
            // Output is held at zero whenever no result is being written.
            pix_q <= v2_q ? pix_d : '0;
        end
    end

    assign bus.out_valid = v3_q;
    assign bus.pix_out   = pix_q;

endmodule

// File: rtl/sobel_stage.sv
// Frame controller around sobel_kernel: issues window reads, counts results.
// Build option: SOBEL_THRESH_EN selects binarized output at THRESH.
module sobel_stage
    import sobel_pkg::*;
#(
    parameter int unsigned IMG_W  = IMG_W_DEF,
    parameter int unsigned IMG_H  = IMG_H_DEF,
    parameter int unsigned THRESH = 128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    input  logic [PIX_W-1:0] pixelr1,
    input  logic [PIX_W-1:0] pixelr2,
    input  logic [PIX_W-1:0] pixelr3,
    input  logic [PIX_W-1:0] pixelr4,
    input  logic [PIX_W-1:0] pixelr5,
    input  logic [PIX_W-1:0] pixelr6,
    input  logic [PIX_W-1:0] pixelr7,
    input  logic [PIX_W-1:0] pixelr8,
    input  logic [PIX_W-1:0] pixelr9,
    output logic             rd,
    output logic             wr,
    output logic [PIX_W-1:0] pixelw,
    output logic             busy,
    output logic             frame_done
);

    localparam int unsigned NPIX  = IMG_W * IMG_H;
    localparam int unsigned CNT_W = $clog2(NPIX + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NPIX - 1);

    state_e           state_q;
    logic [CNT_W-1:0] issue_q, out_cnt_q;
    logic             rd_q, busy_q, frame_done_q;
    logic             active;

    sobel_stage_if u_bus ();

    // Windows are only taken while a frame is in flight.
    assign active         = (state_q == ST_RUN) || (state_q == ST_FLUSH);
    assign u_bus.in_valid = in_valid & active;
    assign u_bus.win[0]   = pixelr1;
    assign u_bus.win[1]   = pixelr2;
    assign u_bus.win[2]   = pixelr3;
    assign u_bus.win[3]   = pixelr4;
    assign u_bus.win[4]   = pixelr5;
    assign u_bus.win[5]   = pixelr6;
    assign u_bus.win[6]   = pixelr7;
    assign u_bus.win[7]   = pixelr8;
    assign u_bus.win[8]   = pixelr9;

    sobel_kernel #(.THRESH(THRESH)) u_kernel (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_bus)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            issue_q      <= '0;
            out_cnt_q    <= '0;
            rd_q         <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if (u_bus.out_valid && active) begin
                out_cnt_q <= out_cnt_q + CNT_W'(1);
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_RUN;
                        issue_q <= '0;
                        rd_q    <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    issue_q <= issue_q + CNT_W'(1);
                    if (issue_q == LAST) begin
                        state_q <= ST_FLUSH;
                        rd_q    <= 1'b0;
                    end
                end
                ST_FLUSH: begin
                    // The final write completes the frame; the counter wraps here.
                    if (u_bus.out_valid && (out_cnt_q == LAST)) begin
                        state_q      <= ST_DONE;
                        out_cnt_q    <= '0;
                        frame_done_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rd         = rd_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign wr         = u_bus.out_valid;
    assign pixelw     = u_bus.pix_out;

endmodule

// File: tb/tb_sobel_stage.sv
// Directed bench for sobel_stage: kernel vectors, full frames, abort by reset.
module tb_sobel_stage;

    logic clk = 1'b0;
    logic rst_n, start;
    logic rd, busy, frame_done;

    sobel_stage_if bus ();

    always #5 clk = ~clk;

    sobel_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .in_valid   (bus.in_valid),
        .pixelr1    (bus.win[0]),
        .pixelr2    (bus.win[1]),
        .pixelr3    (bus.win[2]),
        .pixelr4    (bus.win[3]),
        .pixelr5    (bus.win[4]),
        .pixelr6    (bus.win[5]),
        .pixelr7    (bus.win[6]),
        .pixelr8    (bus.win[7]),
        .pixelr9    (bus.win[8]),
        .rd         (rd),
        .wr         (bus.out_valid),
        .pixelw     (bus.pix_out),
        .busy       (busy),
        .frame_done (frame_done)
    );

    int checks = 0;
    int errors = 0;
    int wr_cnt, rd_cnt, fd_cnt, acc_k;
    logic rd_d;
    logic pv [3];
    logic [7:0] pe [3];
    logic cur_ev;
    logic [7:0] cur_ep;
    logic [7:0] vec_win [8][9];
    int vec_sum [8];

    function automatic logic [7:0] exp_of(input int s);
`ifdef SOBEL_THRESH_EN
        return (s >= 128) ? 8'd255 : 8'd0;
`else
        return (s > 255) ? 8'd255 : 8'(s);
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_pipe();
        for (int i = 0; i < 3; i++) begin
            pv[i] = 1'b0;
            pe[i] = 8'd0;
        end
    endtask

    // One clock: the result of what was driven three edges ago must appear now.
    task automatic tick();
        @(posedge clk);
        #1;
        pv[2] = pv[1]; pe[2] = pe[1];
        pv[1] = pv[0]; pe[1] = pe[0];
        pv[0] = cur_ev; pe[0] = cur_ep;
        chk("wr", bus.out_valid, pv[2]);
        chk("pixelw", bus.pix_out, pv[2] ? pe[2] : 8'd0);
        wr_cnt += int'(bus.out_valid);
        rd_cnt += int'(rd);
        fd_cnt += int'(frame_done);
    endtask

    // Upstream model: in_valid is rd delayed by one cycle.
    task automatic frame_cycle();
        int idx;
        bus.in_valid = rd_d;
        cur_ev = rd_d;
        cur_ep = 8'd0;
        if (rd_d) begin
            idx = (acc_k < 7) ? acc_k : 7;
            for (int i = 0; i < 9; i++) bus.win[i] = vec_win[idx][i];
            cur_ep = exp_of(vec_sum[idx]);
            acc_k++;
        end
        rd_d = rd;
        tick();
    endtask

    task automatic begin_frame();
        wr_cnt = 0; rd_cnt = 0; fd_cnt = 0; acc_k = 0; rd_d = 1'b0;
        start = 1'b1;
        frame_cycle();
        start = 1'b0;
        chk("rd_after_start", rd, 1'b1);
        chk("busy_after_start", busy, 1'b1);
    endtask

    task automatic finish_frame(input string name);
        for (int n = 0; n < 5000 && fd_cnt == 0; n++) frame_cycle();
        chk({name, "_frame_done"}, fd_cnt, 1);
        chk({name, "_rd_cycles"}, rd_cnt, 4096);
        chk({name, "_wr_pulses"}, wr_cnt, 4096);
        frame_cycle();
        chk({name, "_done_pulse_width"}, frame_done, 1'b0);
        chk({name, "_busy_end"}, busy, 1'b0);
        chk({name, "_fd_total"}, fd_cnt, 1);
    endtask

    initial begin
        vec_win[0] = '{100, 100, 100, 100, 100, 100, 100, 100, 100}; vec_sum[0] = 0;
        vec_win[1] = '{0, 0, 255, 0, 0, 255, 0, 0, 255};             vec_sum[1] = 1020;
        vec_win[2] = '{0, 0, 10, 0, 0, 20, 0, 0, 10};                vec_sum[2] = 60;
        vec_win[3] = '{0, 0, 0, 0, 0, 0, 50, 50, 50};                vec_sum[3] = 200;
        vec_win[4] = '{30, 0, 0, 30, 0, 0, 30, 0, 0};                vec_sum[4] = 120;
        vec_win[5] = '{0, 0, 200, 0, 0, 0, 0, 0, 0};                 vec_sum[5] = 400;
        vec_win[6] = '{0, 0, 0, 0, 0, 0, 0, 0, 60};                  vec_sum[6] = 120;
        vec_win[7] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};                   vec_sum[7] = 0;

        rst_n = 1'b0; start = 1'b0; bus.in_valid = 1'b0;
        for (int i = 0; i < 9; i++) bus.win[i] = 8'd0;
        cur_ev = 1'b0; cur_ep = 8'd0; clear_pipe();
        wr_cnt = 0; rd_cnt = 0; fd_cnt = 0; acc_k = 0; rd_d = 1'b0;

        tick();
        tick();
        chk("rst_rd", rd, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_frame_done", frame_done, 1'b0);
        rst_n = 1'b1;

        // Windows offered while idle must vanish.
        for (int i = 0; i < 9; i++) bus.win[i] = vec_win[1][i];
        bus.in_valid = 1'b1;
        for (int n = 0; n < 5; n++) tick();
        bus.in_valid = 1'b0;
        chk("idle_wr_total", wr_cnt, 0);
        chk("idle_busy", busy, 1'b0);
        chk("idle_rd", rd, 1'b0);

        // Frame 1: kernel vectors at its head, a stray start mid-RUN.
        begin_frame();
        for (int n = 0; n < 5000 && rd_cnt < 2000; n++) frame_cycle();
        start = 1'b1;
        frame_cycle();
        start = 1'b0;
        chk("start_in_run_rd", rd, 1'b1);
        finish_frame("f1");

        // Frame 2: reset at pixel 1000 aborts it.
        begin_frame();
        for (int n = 0; n < 5000 && rd_cnt < 1000; n++) frame_cycle();
        chk("pre_abort_rd", rd, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("abort_rd", rd, 1'b0);
        chk("abort_wr", bus.out_valid, 1'b0);
        chk("abort_pixelw", bus.pix_out, 8'd0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_frame_done", frame_done, 1'b0);
        bus.in_valid = 1'b0; cur_ev = 1'b0; cur_ep = 8'd0; rd_d = 1'b0;
        clear_pipe();
        wr_cnt = 0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int n = 0; n < 5; n++) frame_cycle();
        chk("abort_no_frame_done", fd_cnt, 0);
        chk("abort_no_wr", wr_cnt, 0);
        chk("abort_idle", busy, 1'b0);

        // Frame 3: clean full frame after the abort.
        begin_frame();
        finish_frame("f3");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
